// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, IR field positions,
// sequencer states, opcode classes and the datapath strobe bundle.
package cpu_pkg;

  localparam int OPC_W  = 5;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [8:0] {
    RST  = 9'h001,
    T0   = 9'h002,
    T1   = 9'h004,
    T2   = 9'h008,
    T3   = 9'h010,
    T4   = 9'h020,
    T5   = 9'h040,
    T6   = 9'h080,
    HALT = 9'h100
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU3, CLS_MULDIV, CLS_MFHI, CLS_MFLO, CLS_UNARY, CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic             run;
    logic [OPC_W-1:0] alu_op;
    logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, r_out, r_in;
    logic gra, grb, grc;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in;
    logic inc_pc, read;
  } ctrl_t;

  // Undefined opcodes fall into CLS_NOP so they retire after an empty T3.
  function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
    op_class_t c;
    c = CLS_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: c = CLS_ALU3;
      OP_MUL, OP_DIV:                  c = CLS_MULDIV;
      OP_MFHI:                         c = CLS_MFHI;
      OP_MFLO:                         c = CLS_MFLO;
      OP_NEG, OP_NOT:                  c = CLS_UNARY;
      OP_HALT:                         c = CLS_HALT;
      default:                         c = CLS_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational state + latched opcode -> datapath strobe table.
// Every strobe defaults low; alu_op is nonzero only on the ALU-issue step.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  op_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    ctrl     = '0;
    ctrl.run = 1'b1;
    case (state)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
      end
      T1: begin
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      T3: begin
        case (cls)
          CLS_ALU3:   begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          CLS_MULDIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          CLS_MFHI:   begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_MFLO:   begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_UNARY: begin
            ctrl.grb      = 1'b1;
            ctrl.r_out    = 1'b1;
            ctrl.alu_op   = opcode;
            ctrl.zhigh_in = 1'b1;
            ctrl.zlow_in  = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV: begin
            // Second operand comes from Rc for ALU ops, Rb for mul/div.
            ctrl.grc      = (cls == CLS_ALU3);
            ctrl.grb      = (cls == CLS_MULDIV);
            ctrl.r_out    = 1'b1;
            ctrl.alu_op   = opcode;
            ctrl.zhigh_in = 1'b1;
            ctrl.zlow_in  = 1'b1;
          end
          CLS_UNARY: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_ALU3:   begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_MULDIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
      end
      HALT: ctrl.run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore T-state sequencer: owns the state and latched-opcode registers and
// drives the datapath strobes through ctrl_decode; mem_ready only gates T1.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [IRW-1:0] IR,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           MDRout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           HIout,
  output logic           LOout,
  output logic           Rout,
  output logic           Rin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           ZHighIn,
  output logic           ZLowIn,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] alu_op,
  output logic           run
);

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  op_class_t      cls;
  ctrl_t          ctrl;
  logic           unused_ir_bits;

  assign cls            = op_class(opcode_q);
  assign unused_ir_bits = ^IR[OP_LSB-1:0];

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1:  if (mem_ready) state_d = T2;
      T2: begin
        state_d  = T3;
        opcode_d = IR[OP_MSB:OP_LSB];
      end
      T3: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_d = T4;
          CLS_HALT:                        state_d = HALT;
          default:                         state_d = T0;
        endcase
      end
      T4:   state_d = (cls == CLS_UNARY)  ? T0 : T5;
      T5:   state_d = (cls == CLS_MULDIV) ? T6 : T0;
      T6:   state_d = T0;
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= RST;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode_q),
    .ctrl   (ctrl)
  );

  assign PCout    = ctrl.pc_out;
  assign MDRout   = ctrl.mdr_out;
  assign Zhighout = ctrl.zhigh_out;
  assign Zlowout  = ctrl.zlow_out;
  assign HIout    = ctrl.hi_out;
  assign LOout    = ctrl.lo_out;
  assign Rout     = ctrl.r_out;
  assign Rin      = ctrl.r_in;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign MARin    = ctrl.mar_in;
  assign PCin     = ctrl.pc_in;
  assign MDRin    = ctrl.mdr_in;
  assign IRin     = ctrl.ir_in;
  assign Yin      = ctrl.y_in;
  assign HIin     = ctrl.hi_in;
  assign LOin     = ctrl.lo_in;
  assign ZHighIn  = ctrl.zhigh_in;
  assign ZLowIn   = ctrl.zlow_in;
  assign IncPC    = ctrl.inc_pc;
  assign Read     = ctrl.read;
  assign alu_op   = ctrl.alu_op;
  assign run      = ctrl.run;

  // The shared bus and the register-field selects must never be double-driven.
  assert property (@(posedge clock) disable iff (!clear)
    $onehot0({PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout}));
  assert property (@(posedge clock) disable iff (!clear)
    $onehot0({Gra, Grb, Grc}));

endmodule

// File: tb/tb_control_sequencer.sv
// Drives instruction streams with random memory waits and compares every cycle's
// strobes against a per-instruction micro-step list built from the ISA table.
module tb_control_sequencer;

  typedef struct packed {
    logic       run;
    logic [4:0] alu_op;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Rin;
    logic Gra, Grb, Grc;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
    logic IncPC, Read;
  } sig_t;

  logic        clock, clear, mem_ready;
  logic [31:0] IR;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Rin;
  logic Gra, Grb, Grc;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic IncPC, Read, run;
  logic [4:0] alu_op;

  sig_t cur;
  assign cur = {run, alu_op, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout, Rin,
                Gra, Grb, Grc, MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                IncPC, Read};

  int checks = 0;
  int errors = 0;

  sig_t exp_q[$];
  sig_t obs_q[$];
  logic plan_q[$];

  control_sequencer #(.OPW(5), .IRW(32)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .Rout(Rout), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .alu_op(alu_op), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic sig_t idle();
    sig_t v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    return r;
  endfunction

  // Reference: fetch (T0, T1 repeated w+1 times, T2) followed by the
  // opcode's execute micro-steps, with the mem_ready value to drive each cycle.
  task automatic build_model(input logic [31:0] ir, input int w);
    logic [4:0] op;
    sig_t v;
    op = ir[31:27];
    exp_q.delete();
    plan_q.delete();
    v = idle(); v.PCout = 1; v.MARin = 1; v.IncPC = 1;
    exp_q.push_back(v); plan_q.push_back(1'($urandom));
    for (int k = 0; k <= w; k++) begin
      v = idle(); v.Read = 1; v.MDRin = 1;
      exp_q.push_back(v); plan_q.push_back(k == w);
    end
    v = idle(); v.MDRout = 1; v.IRin = 1;
    exp_q.push_back(v); plan_q.push_back(1'($urandom));
    if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                   5'b01000, 5'b01001, 5'b01010, 5'b01011}) begin
      v = idle(); v.Grb = 1; v.Rout = 1; v.Yin = 1; exp_q.push_back(v);
      v = idle(); v.Grc = 1; v.Rout = 1; v.alu_op = op; v.ZHighIn = 1; v.ZLowIn = 1;
      exp_q.push_back(v);
      v = idle(); v.Zlowout = 1; v.Gra = 1; v.Rin = 1; exp_q.push_back(v);
    end else if (op inside {5'b01111, 5'b10000}) begin
      v = idle(); v.Gra = 1; v.Rout = 1; v.Yin = 1; exp_q.push_back(v);
      v = idle(); v.Grb = 1; v.Rout = 1; v.alu_op = op; v.ZHighIn = 1; v.ZLowIn = 1;
      exp_q.push_back(v);
      v = idle(); v.Zlowout = 1; v.LOin = 1; exp_q.push_back(v);
      v = idle(); v.Zhighout = 1; v.HIin = 1; exp_q.push_back(v);
    end else if (op == 5'b10111) begin
      v = idle(); v.HIout = 1; v.Gra = 1; v.Rin = 1; exp_q.push_back(v);
    end else if (op == 5'b11000) begin
      v = idle(); v.LOout = 1; v.Gra = 1; v.Rin = 1; exp_q.push_back(v);
    end else if (op inside {5'b10001, 5'b10010}) begin
      v = idle(); v.Grb = 1; v.Rout = 1; v.alu_op = op; v.ZHighIn = 1; v.ZLowIn = 1;
      exp_q.push_back(v);
      v = idle(); v.Zlowout = 1; v.Gra = 1; v.Rin = 1; exp_q.push_back(v);
    end else begin
      exp_q.push_back(idle());
    end
    while (plan_q.size() < exp_q.size()) plan_q.push_back(1'($urandom));
  endtask

  // Runs ncyc cycles (all of them if ncyc < 0) starting at T0, recording
  // outputs; IR is scrambled after T2 so execute must use the latched opcode.
  task automatic run_instr(input logic [31:0] ir, input int w, input int ncyc);
    int n;
    build_model(ir, w);
    obs_q.delete();
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    IR = ir;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs_q.push_back(cur);
      mem_ready = plan_q[i];
      if (i > w + 2) IR = $urandom;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (cur !== idle()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", cur, idle());
    end
    clear = 1'b1;
    run_instr(32'h18918000, 0, 5);
    #2 clear = 1'b0;
    #1 checks++;
    if (cur !== idle()) begin
      errors++; $display("FAIL reset_async_mid_t4: got %h expected %h", cur, idle());
    end
    @(negedge clock);
    checks++;
    if (cur !== idle()) begin
      errors++; $display("FAIL reset_held: got %h expected %h", cur, idle());
    end
    clear = 1'b1;
    run_instr(mk_ir(5'b11010), 0, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL refetch_after_reset cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_add();
    for (int r = 0; r < 2; r++) begin
      run_instr(32'h18918000, 0, -1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL add cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q[4].alu_op !== 5'b00011) begin
        errors++; $display("FAIL add_alu_op: got %b expected 00011", obs_q[4].alu_op);
      end
    end
  endtask

  task automatic test_mem_wait();
    int reads;
    run_instr(32'h18918000, 3, -1);
    reads = 0;
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mem_wait cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].Read && obs_q[i].MDRin) reads++;
    end
    checks++;
    if (reads !== 4) begin
      errors++; $display("FAIL mem_wait_read_cycles: got %0d expected 4", reads);
    end
    checks++;
    if (obs_q[5].IRin !== 1'b1) begin
      errors++; $display("FAIL mem_wait_irin: got %b expected 1", obs_q[5].IRin);
    end
  endtask

  task automatic test_mul();
    run_instr({5'b01111, 4'd3, 4'd1, 19'd0}, 0, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mul cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== 7 || obs_q[6].HIin !== 1'b1) begin
      errors++; $display("FAIL mul_t6_hiin: got %b expected 1", obs_q[obs_q.size()-1].HIin);
    end
  endtask

  task automatic test_halt();
    run_instr(mk_ir(5'b11011), 1, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt_fetch cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      mem_ready = 1'($urandom);
      IR = $urandom;
      checks++;
      if (cur !== sig_t'(0)) begin
        errors++; $display("FAIL halted cyc%0d: got %h expected 0", c, cur);
      end
    end
    #2 clear = 1'b0;
    #1 checks++;
    if (cur !== idle()) begin
      errors++; $display("FAIL halt_clear: got %h expected %h", cur, idle());
    end
    @(negedge clock);
    clear = 1'b1;
    run_instr(mk_ir(5'b00100), 0, -1);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_after_halt cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_undefined();
    int writes;
    run_instr(mk_ir(5'b11111), 0, -1);
    writes = 0;
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL undefined cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      writes += int'(obs_q[i].Rin) + int'(obs_q[i].HIin) + int'(obs_q[i].LOin);
    end
    checks++;
    if (writes !== 0) begin
      errors++; $display("FAIL undefined_writes: got %0d expected 0", writes);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int n = 0; n < 150; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr(mk_ir(op), $urandom_range(0, 3), -1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random n%0d op%b cyc%0d: got %h expected %h", n, op, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    clear     = 1'b0;
    mem_ready = 1'b0;
    IR        = '0;
    test_reset();
    test_add();
    test_mem_wait();
    test_mul();
    test_undefined();
    test_back_to_back();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
